id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register with operand-forwarding datapath and load-use interlock.
- Latches the decoded instruction from ID and resolves operands A/B through 4:1 forwarding muxes. The muxes are steered by the 2-bit selects from the forwarding controller.
- Its registered ex_dest/ex_wb_en are the controller's EX-stage destination and write-enable inputs.
- Inserts one bubble on a load-use hazard and on flush; keeps a saturating stall counter.

Parameters:
- DATA_W, 16, operand/result width
- REG_AW, 3, register address width
- CTRL_W, 6, opaque EX control bundle width (ALU op etc.)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_src1, id_src2  in  REG_AW  source register addresses
- id_use_src1, id_use_src2  in  1  instruction actually reads src1/src2
- id_dest  in  REG_AW  destination register
- id_wb_en  in  1  instruction writes the register file
- id_mem_rd  in  1  instruction is a load
- id_ctrl  in  CTRL_W  EX control bundle
- id_rf_data1, id_rf_data2  in  DATA_W  register-file read data
- fwd_sel_a, fwd_sel_b  in  2  00=RF, 01=EX stage, 10=MEM stage, 11=WB stage
- ex_fwd_data  in  DATA_W  EX-stage ALU result (combinational)
- mem_fwd_data  in  DATA_W  MEM-stage final result: load data or passed-through ALU result
- wb_fwd_data  in  DATA_W  WB-stage write data
- flush  in  1  branch taken/redirect: squash instruction in ID
- ex_valid, ex_wb_en, ex_mem_rd  out  1  registered EX-stage flags
- ex_dest  out  REG_AW  registered destination
- ex_ctrl  out  CTRL_W  registered control bundle
- ex_opa, ex_opb  out  DATA_W  registered forwarded operands
- stall  out  1  combinational; upstream IF/ID must hold
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst_n=0, asynchronous): all ex_* = 0, stall_count = 0. stall goes 0 whenever ex_valid=0.
- Operand mux (combinational, pre-register): opa = RF/EX/MEM/WB per fwd_sel_a; opb likewise per fwd_sel_b.
- load_use = id_valid & ex_valid & ex_mem_rd & ex_wb_en & ((id_use_src1 & fwd_sel_a==01) | (id_use_src2 & fwd_sel_b==01)).
- stall = load_use & ~flush.
- Each rising edge, priority order:
  1. flush=1 -> bubble (ex_valid, ex_wb_en, ex_mem_rd = 0; ex_dest, ex_ctrl, ex_opa, ex_opb = 0). stall=0 and counter unchanged, even if load_use.
  2. load_use -> bubble as above; stall_count += 1, saturating at all-ones.
  3. Otherwise -> ex_* latch id_* and muxed operands. ex_valid = id_valid; ex_wb_en and ex_mem_rd are gated by id_valid.
- Latency: 1 cycle, ID -> EX registers.
- Stall is exactly 1 cycle per load-use:
  - the following cycle the load sits in MEM; the controller then drives sel=10 and mem_fwd_data supplies the load data;
  - the interlock cannot re-trigger because EX holds a bubble.
- Bubble has wb_en=0, so the controller never forwards from it.
- Select codes not used by an operand (id_use_srcN=0) are still muxed; the value is don't-care but deterministic.
- No internal FSM beyond the pipeline register and counter; no wrap of stall_count.

Decomposition:
- Shared package: forwarding select encodings FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11, plus DATA_W/REG_AW defaults.
- One sub-module natural: fwd_operand_mux (4:1, DATA_W), instantiated twice for A and B.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with ex_valid=1 -> all ex_* and stall_count read 0 immediately (async); stall=0.
- Passthrough: id_valid=1, sel_a=sel_b=00, rf1=0x1234, rf2=0x00FF, dest=5, wb_en=1 -> next edge ex_opa=0x1234, ex_opb=0x00FF, ex_dest=5, ex_valid=1.
- Forward sources: sel_a=01/10/11 with ex=0xAAAA, mem=0xBBBB, wb=0xCCCC -> ex_opa equals 0xAAAA/0xBBBB/0xCCCC on successive edges; same check for sel_b.
- Load-use: EX holds a load to r3 (ex_mem_rd=1, ex_wb_en=1); ID reads r3 with sel_b=01, use_src2=1:
  - -> stall=1, next edge ex_valid=0, stall_count=1;
  - then sel_b=10, mem=0x5A5A -> ex_opb=0x5A5A, stall=0.
- Load-use with use_src1=0 and sel_a=01 -> no stall, instruction latched.
- Flush during load-use: flush=1 with load_use true -> stall=0, bubble latched, stall_count unchanged. Also preload stall_count=0xFFFE and run 3 stall cycles -> saturates at 0xFFFF.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg: forwarding select encodings and width defaults
package id_ex_operand_stage_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;
endpackage

// File: rtl/id_ex_operand_stage_fwd_operand_mux.sv
// fwd_operand_mux: 4:1 operand select between RF read data and EX/MEM/WB bypasses
module fwd_operand_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] rf,
  input  logic [W-1:0] ex,
  input  logic [W-1:0] mem,
  input  logic [W-1:0] wb,
  output logic [W-1:0] y
);
  // pick the freshest copy of the operand named by the forwarding controller
  always_comb y = sel == FWD_EX ? ex : sel == FWD_MEM ? mem : sel == FWD_WB ? wb : rf;
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with operand forwarding and load-use interlock
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use_src1,
  input  logic              id_use_src2,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_rf_data1,
  input  logic [DATA_W-1:0] id_rf_data2,
  input  logic [1:0]        fwd_sel_a,
  input  logic [1:0]        fwd_sel_b,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic [DATA_W-1:0] wb_fwd_data,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_wb_en,
  output logic              ex_mem_rd,
  output logic [REG_AW-1:0] ex_dest,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_opa,
  output logic [DATA_W-1:0] ex_opb,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);
  logic              ex_valid_q, ex_valid_d, ex_wb_en_q, ex_wb_en_d, ex_mem_rd_q, ex_mem_rd_d;
  logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [DATA_W-1:0] ex_opa_q, ex_opa_d, ex_opb_q, ex_opb_d, opa, opb;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_use, bubble;

  // source registers are resolved by the controller; only the selects matter here
  logic unused_src;
  assign unused_src = ^{id_src1, id_src2};

  fwd_operand_mux #(.W(DATA_W)) u_mux_a (
    .sel(fwd_sel_a), .rf(id_rf_data1), .ex(ex_fwd_data), .mem(mem_fwd_data), .wb(wb_fwd_data), .y(opa)
  );
  fwd_operand_mux #(.W(DATA_W)) u_mux_b (
    .sel(fwd_sel_b), .rf(id_rf_data2), .ex(ex_fwd_data), .mem(mem_fwd_data), .wb(wb_fwd_data), .y(opb)
  );

  // hazard detection and next EX contents: flush and load-use both inject a bubble
  always_comb begin
    load_use    = id_valid & ex_valid_q & ex_mem_rd_q & ex_wb_en_q &
                  ((id_use_src1 & (fwd_sel_a == FWD_EX)) | (id_use_src2 & (fwd_sel_b == FWD_EX)));
    stall       = load_use & ~flush;
    bubble      = flush | load_use;
    ex_valid_d  = ~bubble & id_valid;
    ex_wb_en_d  = ~bubble & id_valid & id_wb_en;
    ex_mem_rd_d = ~bubble & id_valid & id_mem_rd;
    ex_dest_d   = bubble ? '0 : id_dest;
    ex_ctrl_d   = bubble ? '0 : id_ctrl;
    ex_opa_d    = bubble ? '0 : opa;
    ex_opb_d    = bubble ? '0 : opb;
    cnt_d       = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  // ID/EX pipeline register and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_wb_en_q  <= 1'b0;
      ex_mem_rd_q <= 1'b0;
      ex_dest_q   <= '0;
      ex_ctrl_q   <= '0;
      ex_opa_q    <= '0;
      ex_opb_q    <= '0;
      cnt_q       <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_wb_en_q  <= ex_wb_en_d;
      ex_mem_rd_q <= ex_mem_rd_d;
      ex_dest_q   <= ex_dest_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_opa_q    <= ex_opa_d;
      ex_opb_q    <= ex_opb_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_wb_en    = ex_wb_en_q;
  assign ex_mem_rd   = ex_mem_rd_q;
  assign ex_dest     = ex_dest_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_opa      = ex_opa_q;
  assign ex_opb      = ex_opb_q;
  assign stall_count = cnt_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed + random checks of id_ex_operand_stage against a behavioural model
module tb_id_ex_operand_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_rd, flush;
  logic [2:0]  id_src1, id_src2, id_dest;
  logic [5:0]  id_ctrl;
  logic [15:0] id_rf_data1, id_rf_data2, ex_fwd_data, mem_fwd_data, wb_fwd_data;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic        ex_valid, ex_wb_en, ex_mem_rd, stall;
  logic [2:0]  ex_dest;
  logic [5:0]  ex_ctrl;
  logic [15:0] ex_opa, ex_opb, stall_count;
  logic        s_valid, s_wb_en, s_mem_rd, s_stall;
  logic [2:0]  s_dest;
  logic [5:0]  s_ctrl;
  logic [15:0] s_opa, s_opb;
  logic [3:0]  s_count;

  int n_pass = 0, n_tot = 0;

  // reference EX-stage contents: what instruction (if any) should sit in EX
  logic        m_valid, m_wb, m_mrd;
  logic [2:0]  m_dest;
  logic [5:0]  m_ctrl;
  logic [15:0] m_opa, m_opb;
  int          m_cnt;

  always #5 clk = ~clk;

  id_ex_operand_stage u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_rd(id_mem_rd), .id_ctrl(id_ctrl), .id_rf_data1(id_rf_data1), .id_rf_data2(id_rf_data2),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_data(wb_fwd_data), .flush(flush), .ex_valid(ex_valid), .ex_wb_en(ex_wb_en),
    .ex_mem_rd(ex_mem_rd), .ex_dest(ex_dest), .ex_ctrl(ex_ctrl), .ex_opa(ex_opa), .ex_opb(ex_opb),
    .stall(stall), .stall_count(stall_count)
  );

  id_ex_operand_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_rd(id_mem_rd), .id_ctrl(id_ctrl), .id_rf_data1(id_rf_data1), .id_rf_data2(id_rf_data2),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_data(wb_fwd_data), .flush(flush), .ex_valid(s_valid), .ex_wb_en(s_wb_en),
    .ex_mem_rd(s_mem_rd), .ex_dest(s_dest), .ex_ctrl(s_ctrl), .ex_opa(s_opa), .ex_opb(s_opb),
    .stall(s_stall), .stall_count(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] pick(input logic [1:0] s, input logic [15:0] rf);
    logic [15:0] t [4];
    t = '{rf, ex_fwd_data, mem_fwd_data, wb_fwd_data};
    return t[s];
  endfunction

  function automatic int sat(input int v, input int max);
    return v > max ? max : v;
  endfunction

  task automatic model_reset();
    {m_valid, m_wb, m_mrd, m_dest, m_ctrl, m_opa, m_opb} = '0;
    m_cnt = 0;
  endtask

  task automatic idle();
    {id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_rd, flush} = '0;
    {id_src1, id_src2, id_dest, id_ctrl, fwd_sel_a, fwd_sel_b} = '0;
    {id_rf_data1, id_rf_data2, ex_fwd_data, mem_fwd_data, wb_fwd_data} = '0;
  endtask

  // called at a negedge with ID inputs already driven; advances one clock and checks EX
  task automatic step(input string tag);
    logic lu;
    #1;
    lu = id_valid && m_valid && m_mrd && m_wb &&
         ((id_use_src1 && fwd_sel_a == 2'b01) || (id_use_src2 && fwd_sel_b == 2'b01));
    chk({tag, ".stall"}, 32'(stall), 32'(lu && !flush));
    chk({tag, ".stall4"}, 32'(s_stall), 32'(lu && !flush));
    if (flush || lu) begin
      {m_valid, m_wb, m_mrd, m_dest, m_ctrl, m_opa, m_opb} = '0;
      if (!flush) m_cnt++;
    end else begin
      m_valid = id_valid;
      m_wb    = id_valid && id_wb_en;
      m_mrd   = id_valid && id_mem_rd;
      m_dest  = id_dest;
      m_ctrl  = id_ctrl;
      m_opa   = pick(fwd_sel_a, id_rf_data1);
      m_opb   = pick(fwd_sel_b, id_rf_data2);
    end
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".wb_en"}, 32'(ex_wb_en), 32'(m_wb));
    chk({tag, ".mem_rd"}, 32'(ex_mem_rd), 32'(m_mrd));
    chk({tag, ".dest"}, 32'(ex_dest), 32'(m_dest));
    chk({tag, ".ctrl"}, 32'(ex_ctrl), 32'(m_ctrl));
    chk({tag, ".opa"}, 32'(ex_opa), 32'(m_opa));
    chk({tag, ".opb"}, 32'(ex_opb), 32'(m_opb));
    chk({tag, ".count"}, 32'(stall_count), 32'(sat(m_cnt, 16'hFFFF)));
    chk({tag, ".count4"}, 32'(s_count), 32'(sat(m_cnt, 15)));
    @(negedge clk);
  endtask

  task automatic load_r3();
    idle();
    id_valid = 1; id_dest = 3; id_wb_en = 1; id_mem_rd = 1; id_ctrl = 6'h11;
    step("load");
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.valid", 32'(ex_valid), 0);
    chk("reset.count", 32'(stall_count), 0);
    rst_n = 1;

    // plain register-file operands
    id_valid = 1; id_rf_data1 = 16'h1234; id_rf_data2 = 16'h00FF; id_dest = 5; id_wb_en = 1; id_ctrl = 6'h2A;
    step("pass");
    chk("pass.opa_const", 32'(ex_opa), 32'h1234);
    chk("pass.opb_const", 32'(ex_opb), 32'h00FF);

    // every bypass source on each operand
    ex_fwd_data = 16'hAAAA; mem_fwd_data = 16'hBBBB; wb_fwd_data = 16'hCCCC;
    for (int s = 1; s < 4; s++) begin
      fwd_sel_a = 2'(s); fwd_sel_b = 2'(4 - s);
      step("fwd");
    end
    chk("fwd.opa_wb_const", 32'(ex_opa), 32'hCCCC);
    chk("fwd.opb_ex_const", 32'(ex_opb), 32'hAAAA);

    // load-use on src2: one stall, then MEM bypass supplies the load data
    load_r3();
    idle();
    id_valid = 1; id_src2 = 3; id_use_src2 = 1; fwd_sel_b = 2'b01; id_dest = 4; id_wb_en = 1;
    step("lu");
    chk("lu.count_const", 32'(stall_count), 1);
    fwd_sel_b = 2'b10; mem_fwd_data = 16'h5A5A;
    step("lu_mem");
    chk("lu_mem.opb_const", 32'(ex_opb), 32'h5A5A);

    // EX select on an unused operand does not interlock
    load_r3();
    idle();
    id_valid = 1; id_src1 = 3; id_use_src1 = 0; fwd_sel_a = 2'b01; ex_fwd_data = 16'h7777; id_dest = 6;
    step("nouse");

    // flush wins over a load-use hazard
    load_r3();
    idle();
    id_valid = 1; id_src1 = 3; id_use_src1 = 1; fwd_sel_a = 2'b01; flush = 1;
    step("flush");

    // repeated stalls drive the narrow counter into saturation
    for (int i = 0; i < 17; i++) begin
      load_r3();
      idle();
      id_valid = 1; id_use_src1 = 1; fwd_sel_a = 2'b01;
      step("satur");
    end
    chk("satur.count4_const", 32'(s_count), 32'hF);

    // random traffic, biased so loads and EX selects occur often
    for (int i = 0; i < 400; i++) begin
      id_valid = 1'($urandom_range(0, 3) != 0);
      id_src1 = 3'($urandom); id_src2 = 3'($urandom); id_dest = 3'($urandom);
      id_use_src1 = 1'($urandom); id_use_src2 = 1'($urandom);
      id_wb_en = 1'($urandom); id_mem_rd = 1'($urandom);
      id_ctrl = 6'($urandom);
      id_rf_data1 = 16'($urandom); id_rf_data2 = 16'($urandom);
      ex_fwd_data = 16'($urandom); mem_fwd_data = 16'($urandom); wb_fwd_data = 16'($urandom);
      fwd_sel_a = 2'($urandom); fwd_sel_b = 2'($urandom);
      flush = 1'($urandom_range(0, 7) == 0);
      step("rand");
    end

    // asynchronous reset mid-cycle while EX holds a valid instruction
    idle();
    id_valid = 1; id_wb_en = 1; id_mem_rd = 1; id_dest = 7; id_ctrl = 6'h3F; id_rf_data1 = 16'hBEEF;
    step("pre_rst");
    chk("pre_rst.valid_const", 32'(ex_valid), 1);
    id_use_src1 = 1; fwd_sel_a = 2'b01;
    #2 rst_n = 0;
    #1;
    chk("arst.valid", 32'(ex_valid), 0);
    chk("arst.wb_en", 32'(ex_wb_en), 0);
    chk("arst.mem_rd", 32'(ex_mem_rd), 0);
    chk("arst.dest", 32'(ex_dest), 0);
    chk("arst.ctrl", 32'(ex_ctrl), 0);
    chk("arst.ops", 32'({ex_opa, ex_opb}), 0);
    chk("arst.count", 32'(stall_count), 0);
    chk("arst.stall", 32'(stall), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    step("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
